// File: rtl/am25ls_selscan.sv
// Registered N-channel, WIDTH-bit data selector with a loadable channel register.
// Optional round-robin scan mode (increment + wrap pulse) is built when AM25LS_SCAN_EN is defined.
module am25ls_selscan #(
    parameter int CH    = 4,
    parameter int WIDTH = 1,
    parameter int SW    = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*WIDTH-1:0]   d,
    input  logic [SW-1:0]         sel,
    input  logic                  ld,
    input  logic                  g,
    input  logic                  scan,
    input  logic                  step,
    output logic [WIDTH-1:0]      y,
    output logic [SW-1:0]         ch,
    output logic                  wrap
);

    localparam logic [SW:0]   CH_L = (SW+1)'(CH);
    localparam logic [SW-1:0] LAST = SW'(CH - 1);

    logic [WIDTH-1:0] w_chan [CH];
    logic             w_ld_ok;
    logic             w_adv;
    logic             w_wrap_evt;
    logic [SW-1:0]    w_ch_inc;

    logic [SW-1:0]    r_ch;
    logic [WIDTH-1:0] r_y;
    logic             r_wrap;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        assign w_chan[i] = d[i*WIDTH +: WIDTH];
    end

    // Out-of-range loads are dropped so r_ch can never address a missing channel.
    assign w_ld_ok = ld && ({1'b0, sel} < CH_L);

`ifdef AM25LS_SCAN_EN
    // Any ld, even an ignored one, pre-empts the scan step.
    assign w_adv = scan && step && !ld;
`else
    logic w_unused_scan;
    assign w_unused_scan = scan ^ step;
    assign w_adv = 1'b0;
`endif

    assign w_wrap_evt = w_adv && (r_ch == LAST);
    assign w_ch_inc   = (r_ch == LAST) ? '0 : r_ch + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch   <= '0;
            r_y    <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (w_ld_ok) begin
                r_ch <= sel;
            end else if (w_adv) begin
                r_ch <= w_ch_inc;
            end
            r_y    <= g ? '0 : w_chan[r_ch];
            r_wrap <= w_wrap_evt;
        end
    end

    assign y    = r_y;
    assign ch   = r_ch;
    assign wrap = r_wrap;

endmodule

// File: doc/am25ls_selscan.md
# am25ls_selscan

Parametrised, registered N-channel, W-bit data selector with a held channel register and an optional auto-scan mode. It generalises the 4-line-to-1 selector family to arbitrary width and channel count, and adds registered output, loadable channel select and round-robin sequencing. It sits in datapaths that time-multiplex several sources onto one bus, such as status polling and register-file readout.

## Interface
Parameters:
- CH, 4: number of input channels; any integer 2..16.
- WIDTH, 1: bits per channel.
- SW, $clog2(CH): select/channel width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. Synchronous and active-high.
- d  input  CH*WIDTH  channel data; channel i is d[i*WIDTH +: WIDTH].
- sel  input  SW  channel number to load.
- ld  input  1  load sel into the channel register.
- g  input  1  output strobe, active-low. 0 enables y; 1 forces y to 0.
- scan  input  1  scan mode. Ignored unless AM25LS_SCAN_EN is defined.
- step  input  1  advance the channel register in scan mode.
- y  output  WIDTH  registered selected data.
- ch  output  SW  current channel register.
- wrap  output  1  one-cycle pulse when scan wraps from CH-1 to 0.

## Operation
- Reset: ch=0, y=0, wrap=0. Reset overrides every other input.
- Channel register priority per clock: rst, then ld, then (scan & step), then hold.
- ld=1 with sel<CH: ch<=sel.
- ld=1 with sel>=CH: ch holds and the load is ignored. This only applies when CH is not a power of two.
- scan=1, step=1, ld=0: ch<=ch+1, with ch wrapping from CH-1 to 0.
- wrap<=1 only in the cycle after an increment from CH-1 to 0. Otherwise wrap<=0, including when ld pre-empts the step.
- scan=0: step is ignored and ch changes only by ld.
- Output register: y<=(g==0) ? d[ch*WIDTH +: WIDTH] : 0. It uses the pre-update ch and the current d.
- No X propagation: ch is always <CH, so the selected slice is always defined.

## Timing
- Data latency: a change on d at edge t appears on y at edge t+1, given g=0 and ch stable.
- Select latency: ld at edge t updates ch at t+1. y shows the new channel's data at t+2.
- Strobe latency: g rising at t clears y at t+1. g falling at t gives valid data at t+1.
- Scan throughput: one channel per cycle with step held high. A full sweep takes CH cycles.
- wrap is coincident with ch==0 after the wrap.
- Asserting rst mid-scan: at the next edge ch=0, y=0, wrap=0. Scanning resumes from channel 0 on the first edge after rst drops.
- ld and scan&step in the same cycle: ld wins. No increment and no wrap.

## Configuration
- AM25LS_SCAN_EN defined: scan mode is present as described, with the increment logic and the wrap output.
- AM25LS_SCAN_EN undefined: scan and step are ignored and ch changes only by ld or rst. wrap is tied to 0. The block is then a pure registered, loadable selector.

## Test plan
- Reset and load: CH=4, WIDTH=8, d={8'hD3,8'hC2,8'hB1,8'hA0}, g=0. Assert rst 1 cycle, then ld with sel=2 -> ch=2 one cycle after ld, y=8'hC2 two cycles after ld. y=0 during reset.
- Strobe: hold ch=2, drive g=1 for 3 cycles -> y=0 exactly from the edge after g rises, and 8'hC2 from the edge after g falls.
- Scan wrap: AM25LS_SCAN_EN defined, scan=1, step=1 from ch=0 for 6 cycles -> ch sequence 1,2,3,0,1,2. wrap=1 only while ch=0. y lags ch by one cycle: A0,B1,C2,D3,A0...
- Collision: scan&step with ch=3 and ld with sel=1 in the same cycle -> ch=1, wrap=0.
- Out-of-range and mid-scan reset: CH=5, ch=4, ld with sel=6 -> ch stays 4. Then scan a step -> ch=0 with wrap=1. Then rst while scanning -> ch=0, y=0, wrap=0 next edge.
- Macro off: with AM25LS_SCAN_EN undefined, scan=1, step=1 for 8 cycles -> ch is unchanged and wrap stays 0.
